// File: rtl/pe_array_stream.sv
// pe_array_stream: ROWS x COLS output-stationary MAC array.
// Operand beats accumulate under a valid/ready handshake; an accepted beat
// with in_last switches to DRAIN, where requantised rows stream out one per
// handshake. Define PE_ARRAY_STREAM_SATURATE_EN to clamp narrowed outputs
// instead of wrapping them.
module pe_array_stream #(
    parameter int ROWS              = 16,
    parameter int COLS              = 16,
    parameter int A_WIDTH           = 8,
    parameter int B_WIDTH           = 8,
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 8,
    parameter int OUTPUT_SCALE      = 0
) (
    input  logic                           clk,
    input  logic                           arst_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic signed [A_WIDTH-1:0]      activations [0:ROWS-1],
    input  logic signed [B_WIDTH-1:0]      weights [0:COLS-1],
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_row [0:COLS-1],
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
    output logic                           busy
);

    localparam int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PROD_W = A_WIDTH + B_WIDTH;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    typedef enum logic {
        ACCUM,
        DRAIN
    } state_t;

    state_t                               state;
    state_t                               state_next;
    logic                                 first;
    logic [IDX_W-1:0]                     row_cnt;
    logic signed [ACCUMULATOR_WIDTH-1:0]  acc     [0:ROWS-1][0:COLS-1];
    logic signed [ACCUMULATOR_WIDTH-1:0]  acc_upd [0:ROWS-1][0:COLS-1];
    logic signed [PROD_W-1:0]             prod    [0:ROWS-1][0:COLS-1];
    logic signed [ACCUMULATOR_WIDTH-1:0]  shifted [0:COLS-1];
    logic                                 beat_acc;
    logic                                 row_hs;

    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == DRAIN);
    assign busy        = (state == DRAIN);
    assign out_row_idx = row_cnt;
    assign beat_acc    = in_valid && in_ready;
    assign row_hs      = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) state <= ACCUM;
        else         state <= state_next;
    end

    // Next-state: last accepted beat starts the drain, final row handshake ends it.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (beat_acc && in_last) state_next = DRAIN;
            DRAIN: if (row_hs && row_cnt == LAST_ROW) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // First-beat flag and drain row counter.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            first   <= 1'b1;
            row_cnt <= '0;
        end else if (beat_acc) begin
            first   <= 1'b0;
            row_cnt <= '0;
        end else if (row_hs) begin
            if (row_cnt == LAST_ROW) begin
                first   <= 1'b1;
                row_cnt <= '0;
            end else begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // Full-width signed products, sign-extended and added (or loaded on the first beat).
    always_comb begin
        for (int unsigned i = 0; i < ROWS; i++) begin
            for (int unsigned j = 0; j < COLS; j++) begin
                prod[i][j]    = PROD_W'(activations[i]) * PROD_W'(weights[j]);
                acc_upd[i][j] = ACCUMULATOR_WIDTH'(prod[i][j]);
                if (!first) acc_upd[i][j] = acc[i][j] + acc_upd[i][j];
            end
        end
    end

    // Accumulator array: updated only on accepted beats, held during the drain.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            for (int unsigned i = 0; i < ROWS; i++)
                for (int unsigned j = 0; j < COLS; j++)
                    acc[i][j] <= '0;
        end else if (beat_acc) begin
            for (int unsigned i = 0; i < ROWS; i++)
                for (int unsigned j = 0; j < COLS; j++)
                    acc[i][j] <= acc_upd[i][j];
        end
    end

`ifdef PE_ARRAY_STREAM_SATURATE_EN
    localparam logic signed [ACCUMULATOR_WIDTH-1:0] SAT_MAX =
        {{(ACCUMULATOR_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUMULATOR_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Requantise the selected row: floor shift, then clamp to the output range.
    always_comb begin
        for (int unsigned j = 0; j < COLS; j++) begin
            shifted[j] = acc[row_cnt][j] >>> OUTPUT_SCALE;
            if (shifted[j] > SAT_MAX)      out_row[j] = SAT_MAX[OUTPUT_WIDTH-1:0];
            else if (shifted[j] < SAT_MIN) out_row[j] = SAT_MIN[OUTPUT_WIDTH-1:0];
            else                           out_row[j] = shifted[j][OUTPUT_WIDTH-1:0];
        end
    end
`else
    // Requantise the selected row: floor shift, then keep the low bits (wrap).
    always_comb begin
        for (int unsigned j = 0; j < COLS; j++) begin
            shifted[j] = acc[row_cnt][j] >>> OUTPUT_SCALE;
            out_row[j] = shifted[j][OUTPUT_WIDTH-1:0];
        end
    end
`endif

endmodule
